// File: rtl/fpu_pkg.sv
// Shared single-precision field constants and the sequential divider FSM states.
package fpu_pkg;
  localparam int EXP_W        = 8;
  localparam int MAN_W        = 23;
  localparam int BIAS         = 127;
  localparam int FDIV_LATENCY = 7;

  localparam logic [EXP_W-1:0] EXP_INF   = 8'hFF;
  localparam logic [31:0]      INF_BITS  = 32'h7F80_0000;
  localparam logic [31:0]      QNAN_BITS = 32'h7FC0_0000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEED,
    ST_NR1A,
    ST_NR1B,
    ST_NR2A,
    ST_NR2B,
    ST_MUL,
    ST_RND,
    ST_DONE
  } fdiv_state_e;
endpackage

// File: rtl/fdiv_seed_rom.sv
// 256x8 reciprocal seed table, combinational. Entry i encodes 1/(1+i/256) as
// (256+entry)/512, i.e. the low 8 bits of a Q0.9 reciprocal whose MSB is always set.
module fdiv_seed_rom (
  input  logic [7:0] idx_i,
  output logic [7:0] seed_o
);
  function automatic logic [7:0] seed_val(input int i);
    int v;
    v = (262144 + 256 + i) / (512 + 2 * i) - 256;
    if (v > 255) v = 255;
    if (v < 0) v = 0;
    return v[7:0];
  endfunction

  logic [7:0] rom_w [256];

  for (genvar g = 0; g < 256; g++) begin : g_rom
    assign rom_w[g] = seed_val(g);
  end

  assign seed_o = rom_w[idx_i];
endmodule

// File: rtl/fdiv_seq.sv
// Sequential FP32 divider: two Newton-Raphson steps on 1/x2 then one multiply by x1.
// Result appears 7 clocks after accept; held in DONE until out_ready, one op in flight.
module fdiv_seq
  import fpu_pkg::*;
#(
  parameter int SEED_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        udf
);
  fdiv_state_e state_q;
  logic [31:0] x1_q, x2_q;
  logic [31:0] x_q;   // reciprocal estimate, Q0.32
  logic [31:0] dt_q;  // 2 - mb*x, Q1.31
  logic [63:0] q_q;   // mantissa quotient, Q1.63
  logic [31:0] y_q;
  logic        ovf_q, udf_q, out_valid_q, in_ready_q;

  logic [7:0]  seed_w;
  logic [31:0] mb1_w, mb2_w, mul_a_w, mul_b_w;
  logic [63:0] prod_w;

  fdiv_seed_rom u_seed_rom (
    .idx_i  (x2_q[MAN_W-1 -: SEED_BITS]),
    .seed_o (seed_w)
  );

  assign mb1_w = {1'b1, x1_q[MAN_W-1:0], 8'h00};
  assign mb2_w = {1'b1, x2_q[MAN_W-1:0], 8'h00};

  // Single shared multiplier; operand A is steered by state, B is always the estimate.
  always_comb begin
    mul_a_w = mb2_w;
    case (state_q)
      ST_NR1B, ST_NR2B: mul_a_w = dt_q;
      ST_MUL:           mul_a_w = mb1_w;
      default:          mul_a_w = mb2_w;
    endcase
  end
  assign mul_b_w = x_q;
  assign prod_w  = {32'd0, mul_a_w} * {32'd0, mul_b_w};

  logic               sgn_w, norm_w, g_w, r_w, s_w, rup_w;
  logic [23:0]        mant_w;
  logic [24:0]        mant_r_w;
  logic [22:0]        frac_w;
  logic signed [9:0]  e_w;
  logic [31:0]        y_w;
  logic               ovf_w, udf_w;

  always_comb begin
    sgn_w  = x1_q[31] ^ x2_q[31];
    norm_w = ~q_q[63];
    if (q_q[63]) begin
      mant_w = q_q[63:40];
      g_w    = q_q[39];
      r_w    = q_q[38];
      s_w    = |q_q[37:0];
    end else begin
      mant_w = q_q[62:39];
      g_w    = q_q[38];
      r_w    = q_q[37];
      s_w    = |q_q[36:0];
    end
    rup_w    = g_w & (r_w | s_w | mant_w[0]);
    mant_r_w = {1'b0, mant_w} + {24'd0, rup_w};
    // A rounding carry leaves 1.000..0, so the shifted fraction is all zeros.
    frac_w   = mant_r_w[24] ? mant_r_w[23:1] : mant_r_w[22:0];
    e_w = $signed({2'b00, x1_q[30:23]}) - $signed({2'b00, x2_q[30:23]}) + 10'sd127
        - $signed({9'd0, norm_w}) + $signed({9'd0, mant_r_w[24]});

    y_w   = {sgn_w, e_w[7:0], frac_w};
    ovf_w = 1'b0;
    udf_w = 1'b0;
    if (x2_q[30:23] == 8'd0) begin
      y_w   = {sgn_w, EXP_INF, 23'd0};
      ovf_w = 1'b1;
    end else if (x1_q[30:23] == 8'd0) begin
      y_w = {sgn_w, 31'd0};
    end else if (e_w > 10'sd254) begin
      y_w   = {sgn_w, INF_BITS[30:0]};
      ovf_w = 1'b1;
    end else if (e_w < 10'sd1) begin
      y_w   = {sgn_w, 31'd0};
      udf_w = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      y_q         <= 32'd0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      x1_q        <= 32'd0;
      x2_q        <= 32'd0;
      x_q         <= 32'd0;
      dt_q        <= 32'd0;
      q_q         <= 64'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            x1_q       <= x1;
            x2_q       <= x2;
            in_ready_q <= 1'b0;
            state_q    <= ST_SEED;
          end
        end
        ST_SEED: begin
          x_q     <= {1'b1, seed_w, 23'd0};
          state_q <= ST_NR1A;
        end
        ST_NR1A: begin
          dt_q    <= 32'd0 - prod_w[63:32];
          state_q <= ST_NR1B;
        end
        ST_NR1B: begin
          x_q     <= prod_w[62:31];
          state_q <= ST_NR2A;
        end
        ST_NR2A: begin
          dt_q    <= 32'd0 - prod_w[63:32];
          state_q <= ST_NR2B;
        end
        ST_NR2B: begin
          x_q     <= prod_w[62:31];
          state_q <= ST_MUL;
        end
        ST_MUL: begin
          // A zero divisor mantissa means the reciprocal is exactly 1.0.
          q_q     <= (x2_q[MAN_W-1:0] == 23'd0) ? {1'b1, x1_q[MAN_W-1:0], 40'd0} : prod_w;
          state_q <= ST_RND;
        end
        ST_RND: begin
          y_q         <= y_w;
          ovf_q       <= ovf_w;
          udf_q       <= udf_w;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;
endmodule
